// File: rtl/fourth_step_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fourth_step_pkg
//  Description : Shared widths, control-bundle type and bubble constant for
//                the MIPS memory-access stage (fourth_step) and its RAM.
//                No ports; imported by fourth_step and data_memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package fourth_step_pkg;

    localparam int DATA_W_DEFAULT = 32;  // datapath width
    localparam int REG_W          = 5;   // register-file index width
    localparam int MEM_AW_DEFAULT = 5;   // data-memory word-address width

    // Control bits carried through EX/MEM.
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic branch;
        logic mem_to_reg;
        logic reg_write;
    } ctrl_t;

    // A bubble is an instruction with every control bit cleared: it never
    // writes memory, never branches and never writes the register file.
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage : fourth_step_pkg
`default_nettype wire

// File: rtl/fourth_step_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory
//  Description : Word-addressed synchronous single-port RAM.
//                Ports: clk, we (write enable), re (read enable),
//                addr[MEM_AW-1:0] (word index), wdata, rdata (registered).
//                A simultaneous read and write returns the old contents.
//                rdata holds its value while re is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory
    import fourth_step_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int MEM_AW = MEM_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [MEM_AW-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** MEM_AW;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Read and write in the same block with non-blocking assignments, so a
    // combined read+write sees the pre-write word.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= r_mem[addr];
        end
    end

endmodule : data_memory
`default_nettype wire

// File: rtl/fourth_step.sv
`default_nettype none
// ============================================================================
//  Module      : fourth_step
//  Description : MIPS memory-access stage. Holds the EX/MEM register, the
//                data memory and the MEM/WB register.
//                Inputs : clk, reset, stall, flush, execute-stage controls
//                         (memRead, memWrite, branch, memToReg, regWrite) and
//                         data (addResult, zero, aluResult, reg2Out,
//                         muxRegDstOut).
//                Outputs: pcSrc / branchTarget to fetch (one edge after
//                         capture); misaligned, memReadData, aluResultOut,
//                         regDstOut, memToRegOut, regWriteOut to write-back
//                         (two edges after capture).
//  Revision    : 1.0 - initial release
// ============================================================================
module fourth_step
    import fourth_step_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int MEM_AW = MEM_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              branch,
    input  logic              memToReg,
    input  logic              regWrite,
    input  logic [DATA_W-1:0] addResult,
    input  logic              zero,
    input  logic [DATA_W-1:0] aluResult,
    input  logic [DATA_W-1:0] reg2Out,
    input  logic [REG_W-1:0]  muxRegDstOut,
    output logic              pcSrc,
    output logic [DATA_W-1:0] branchTarget,
    output logic              misaligned,
    output logic [DATA_W-1:0] memReadData,
    output logic [DATA_W-1:0] aluResultOut,
    output logic [REG_W-1:0]  regDstOut,
    output logic              memToRegOut,
    output logic              regWriteOut
);

    // ---------------- EX/MEM register ----------------
    ctrl_t             r_ex_ctrl;
    logic [DATA_W-1:0] r_ex_add;
    logic              r_ex_zero;
    logic [DATA_W-1:0] r_ex_alu;
    logic [DATA_W-1:0] r_ex_reg2;
    logic [REG_W-1:0]  r_ex_dst;

    ctrl_t w_in_ctrl;
    assign w_in_ctrl = '{mem_read:   memRead,
                         mem_write:  memWrite,
                         branch:     branch,
                         mem_to_reg: memToReg,
                         reg_write:  regWrite};

    // Flush beats stall: a flushed slot always loads its data fields but
    // carries bubble controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_ctrl <= CTRL_BUBBLE;
            r_ex_add  <= '0;
            r_ex_zero <= 1'b0;
            r_ex_alu  <= '0;
            r_ex_reg2 <= '0;
            r_ex_dst  <= '0;
        end else if (flush || !stall) begin
            r_ex_ctrl <= flush ? CTRL_BUBBLE : w_in_ctrl;
            r_ex_add  <= addResult;
            r_ex_zero <= zero;
            r_ex_alu  <= aluResult;
            r_ex_reg2 <= reg2Out;
            r_ex_dst  <= muxRegDstOut;
        end
    end

    assign pcSrc        = r_ex_ctrl.branch & r_ex_zero;
    assign branchTarget = r_ex_add;

    // ---------------- Memory access ----------------
    logic              w_mem_we;
    logic              w_mem_re;
    logic [MEM_AW-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_rdata;

    // Gating the write with reset discards a store that is still sitting in
    // EX/MEM when reset arrives.
    assign w_mem_we   = r_ex_ctrl.mem_write & ~stall & ~reset;
    assign w_mem_re   = r_ex_ctrl.mem_read  & ~stall & ~reset;
    // Byte address -> word index; higher bits dropped so accesses wrap.
    assign w_mem_addr = r_ex_alu[MEM_AW+1:2];

    data_memory #(
        .DATA_W (DATA_W),
        .MEM_AW (MEM_AW)
    ) u_data_memory (
        .clk   (clk),
        .we    (w_mem_we),
        .re    (w_mem_re),
        .addr  (w_mem_addr),
        .wdata (r_ex_reg2),
        .rdata (w_mem_rdata)
    );

    // ---------------- MEM/WB register ----------------
    // r_rd_valid marks that the RAM output register holds this slot's load;
    // for non-loads memReadData reads as zero. Both hold together on stall.
    logic r_rd_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid   <= 1'b0;
            misaligned   <= 1'b0;
            aluResultOut <= '0;
            regDstOut    <= '0;
            memToRegOut  <= 1'b0;
            regWriteOut  <= 1'b0;
        end else if (!stall) begin
            r_rd_valid   <= r_ex_ctrl.mem_read;
            misaligned   <= (r_ex_ctrl.mem_read | r_ex_ctrl.mem_write)
                            & (r_ex_alu[1:0] != 2'b00);
            aluResultOut <= r_ex_alu;
            regDstOut    <= r_ex_dst;
            memToRegOut  <= r_ex_ctrl.mem_to_reg;
            regWriteOut  <= r_ex_ctrl.reg_write;
        end
    end

    assign memReadData = r_rd_valid ? w_mem_rdata : '0;

endmodule : fourth_step
`default_nettype wire

// File: tb/tb_fourth_step.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fourth_step
//  Description : Self-checking bench for fourth_step. Directed scenarios
//                followed by randomized traffic, all compared against a
//                behavioural model of the stage (instruction records plus a
//                word array).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fourth_step;

    localparam int DEPTH = 32;

    typedef struct packed {
        bit          rd;
        bit          wr;
        bit          br;
        bit          m2r;
        bit          rw;
        logic [31:0] add;
        bit          zero;
        logic [31:0] alu;
        logic [31:0] reg2;
        logic [4:0]  dst;
    } ins_t;

    logic clk = 1'b0;
    logic reset, stall, flush;
    ins_t cur;

    logic        pcSrc, misaligned, memToRegOut, regWriteOut;
    logic [31:0] branchTarget, memReadData, aluResultOut;
    logic [4:0]  regDstOut;

    always #5 clk = ~clk;

    fourth_step dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .memRead      (cur.rd),
        .memWrite     (cur.wr),
        .branch       (cur.br),
        .memToReg     (cur.m2r),
        .regWrite     (cur.rw),
        .addResult    (cur.add),
        .zero         (cur.zero),
        .aluResult    (cur.alu),
        .reg2Out      (cur.reg2),
        .muxRegDstOut (cur.dst),
        .pcSrc        (pcSrc),
        .branchTarget (branchTarget),
        .misaligned   (misaligned),
        .memReadData  (memReadData),
        .aluResultOut (aluResultOut),
        .regDstOut    (regDstOut),
        .memToRegOut  (memToRegOut),
        .regWriteOut  (regWriteOut)
    );

    // ---------------- reference model state ----------------
    ins_t        m_ex;
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    logic [31:0] m_rdata, m_alu;
    bit          m_rdata_known, m_mis, m_m2r, m_rw;
    logic [4:0]  m_dst;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One rising edge of the stage, in instruction terms.
    task automatic model_edge();
        int idx;
        if (reset) begin
            m_ex          = '0;
            m_rdata       = '0;
            m_rdata_known = 1'b1;
            m_alu = '0; m_dst = '0; m_m2r = 0; m_rw = 0; m_mis = 0;
        end else begin
            if (!stall) begin
                idx = int'((m_ex.alu / 4) % DEPTH);
                m_rdata       = m_ex.rd ? m_mem[idx] : 32'd0;
                m_rdata_known = m_ex.rd ? m_known[idx] : 1'b1;
                if (m_ex.wr) begin
                    m_mem[idx]   = m_ex.reg2;
                    m_known[idx] = 1'b1;
                end
                m_alu = m_ex.alu;
                m_dst = m_ex.dst;
                m_m2r = m_ex.m2r;
                m_rw  = m_ex.rw;
                m_mis = (m_ex.rd || m_ex.wr) && (m_ex.alu % 4 != 0);
            end
            if (flush) begin
                m_ex = cur;
                m_ex.rd = 0; m_ex.wr = 0; m_ex.br = 0; m_ex.m2r = 0; m_ex.rw = 0;
            end else if (!stall) begin
                m_ex = cur;
            end
        end
    endtask

    task automatic compare_all();
        check_value("pcSrc",        {31'd0, pcSrc},       {31'd0, m_ex.br && m_ex.zero});
        check_value("branchTarget", branchTarget,         m_ex.add);
        check_value("misaligned",   {31'd0, misaligned},  {31'd0, m_mis});
        check_value("aluResultOut", aluResultOut,         m_alu);
        check_value("regDstOut",    {27'd0, regDstOut},   {27'd0, m_dst});
        check_value("memToRegOut",  {31'd0, memToRegOut}, {31'd0, m_m2r});
        check_value("regWriteOut",  {31'd0, regWriteOut}, {31'd0, m_rw});
        if (m_rdata_known)
            check_value("memReadData", memReadData, m_rdata);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    function automatic ins_t nop();
        ins_t i = '0;
        return i;
    endfunction

    function automatic ins_t sw(input logic [31:0] a, input logic [31:0] d);
        ins_t i = '0;
        i.wr = 1; i.alu = a; i.reg2 = d;
        return i;
    endfunction

    function automatic ins_t lw(input logic [31:0] a, input logic [4:0] r);
        ins_t i = '0;
        i.rd = 1; i.m2r = 1; i.rw = 1; i.alu = a; i.dst = r;
        return i;
    endfunction

    logic [31:0] saved;

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            m_mem[k]   = '0;
            m_known[k] = 1'b0;
        end
        m_ex = '0; m_rdata = '0; m_rdata_known = 1'b0;
        m_alu = '0; m_dst = '0; m_m2r = 0; m_rw = 0; m_mis = 0;

        // Reset state
        reset = 1; stall = 0; flush = 0; cur = nop();
        step();
        check_value("reset_memReadData", memReadData, 32'd0);
        step();
        reset = 0;

        // Fill memory so every later read is predictable.
        for (int k = 0; k < DEPTH; k++) begin
            cur = sw(32'(k * 4), $urandom);
            step();
        end

        // Store then load
        cur = sw(32'h10, 32'hDEAD_BEEF);         step();
        cur = lw(32'h10, 5'd5);                  step();
        cur = nop();                             step();
        check_value("sl_data", memReadData, 32'hDEAD_BEEF);
        check_value("sl_dst",  {27'd0, regDstOut}, 32'd5);
        check_value("sl_m2r",  {31'd0, memToRegOut}, 32'd1);

        // Branch taken / not taken
        cur = nop(); cur.br = 1; cur.zero = 1; cur.add = 32'h40; step();
        check_value("br_taken",  {31'd0, pcSrc}, 32'd1);
        check_value("br_target", branchTarget, 32'h40);
        cur.zero = 0;                                         step();
        check_value("br_not_taken", {31'd0, pcSrc}, 32'd0);

        // Stall while a store is presented
        saved = m_mem[8];
        cur = sw(32'h20, 32'h1234); stall = 1;
        repeat (3) step();
        check_value("stall_mem_untouched", m_mem[8], saved);
        stall = 0;                  step();
        cur = lw(32'h20, 5'd7);     step();
        cur = nop();                step();
        check_value("stall_then_load", memReadData, 32'h1234);

        // Flush a store
        saved = m_mem[2];
        cur = sw(32'h08, 32'hFFFF_FFFF); cur.rw = 1; flush = 1; step();
        check_value("flush_pcSrc", {31'd0, pcSrc}, 32'd0);
        flush = 0; cur = lw(32'h08, 5'd3); step();
        check_value("flush_regWriteOut", {31'd0, regWriteOut}, 32'd0);
        cur = nop();                        step();
        check_value("flush_word_kept", memReadData, saved);

        // Reset with a store pending in EX/MEM
        cur = sw(32'h10, 32'h5555_5555); step();
        reset = 1; cur = nop();          step();
        check_value("rst_pcSrc", {31'd0, pcSrc}, 32'd0);
        check_value("rst_alu",   aluResultOut, 32'd0);
        check_value("rst_rw",    {31'd0, regWriteOut}, 32'd0);
        reset = 0; cur = lw(32'h10, 5'd1); step();
        cur = nop();                       step();
        check_value("rst_word_kept", memReadData, 32'hDEAD_BEEF);

        // Misaligned access and address wrap
        cur = lw(32'h13, 5'd2); step();
        cur = lw(32'h90, 5'd4); step();
        check_value("mis_flag", {31'd0, misaligned}, 32'd1);
        check_value("mis_data", memReadData, 32'hDEAD_BEEF);
        cur = nop();            step();
        check_value("wrap_flag", {31'd0, misaligned}, 32'd0);
        check_value("wrap_data", memReadData, 32'hDEAD_BEEF);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cur.rd   = ($urandom_range(0, 2) == 0);
            cur.wr   = ($urandom_range(0, 2) == 0);
            cur.br   = $urandom_range(0, 1);
            cur.m2r  = $urandom_range(0, 1);
            cur.rw   = $urandom_range(0, 1);
            cur.add  = $urandom;
            cur.zero = $urandom_range(0, 1);
            cur.alu  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            cur.reg2 = $urandom;
            cur.dst  = 5'($urandom_range(0, 31));
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            reset    = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fourth_step
`default_nettype wire

// File: doc/fourth_step.md
Name: fourth_step

Overview:
- MIPS memory-access stage. It consumes the execute-stage outputs: ALU result, zero flag, second register operand, destination register and branch target.
- It holds the EX/MEM pipeline register, the word-addressed data memory and the MEM/WB pipeline register.
- It produces the PC-source decision for fetch and the write-back data and control for the register file.
- It sits between third_step and the write-back mux.

Parameters:
- DATA_W, 32, datapath width.
- MEM_AW, 5, data-memory word-address width; depth = 2**MEM_AW words.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold both pipeline registers; suppress memory write.
- flush  in  1  load a bubble into EX/MEM.
- memRead  in  1  control: load.
- memWrite  in  1  control: store.
- branch  in  1  control: beq.
- memToReg  in  1  control, passed to write-back.
- regWrite  in  1  control, passed to write-back.
- addResult  in  DATA_W  branch target from execute.
- zero  in  1  ALU zero flag.
- aluResult  in  DATA_W  ALU result, doubling as byte address.
- reg2Out  in  DATA_W  store data.
- muxRegDstOut  in  5  destination register.
- pcSrc  out  1  take branch.
- branchTarget  out  DATA_W  registered addResult.
- misaligned  out  1  registered flag: access address[1:0] != 0.
- memReadData  out  DATA_W  MEM/WB load data.
- aluResultOut  out  DATA_W  MEM/WB ALU result.
- regDstOut  out  5  MEM/WB destination register.
- memToRegOut  out  1  MEM/WB control.
- regWriteOut  out  1  MEM/WB control.

Behaviour:
- Single clock, clk; reset is synchronous and active-high. Every register updates only on the rising edge of clk.
- Reset: all EX/MEM and MEM/WB fields = 0; all outputs = 0. Memory contents are not cleared. Reset overrides stall and flush.
- EX/MEM capture (edge E0), in priority order:
  - flush: control bits (memRead, memWrite, branch, memToReg, regWrite) = 0; data fields load normally. Flush has priority over stall.
  - else stall: hold.
  - else load all inputs.
- Memory stage (cycle after E0):
  - Word index = EX/MEM aluResult[MEM_AW+1:2]; upper address bits are ignored, so accesses wrap modulo depth.
  - address[1:0] are ignored for the access itself.
  - Write: the word is committed at edge E1 when EX/MEM memWrite=1 and stall=0.
  - Read: synchronous. The word at the index is captured into memReadData at E1 when EX/MEM memRead=1 and stall=0; otherwise memReadData = 0.
  - A load in the cycle immediately after a store to the same address returns the newly stored value.
  - If memRead and memWrite are both set: the write commits and memReadData returns the pre-write contents.
- pcSrc = EX/MEM branch AND EX/MEM zero. It is combinational from the EX/MEM register and valid in the cycle after E0. branchTarget = EX/MEM addResult.
- MEM/WB capture at E1:
  - If not stall: load aluResultOut, regDstOut, memToRegOut, regWriteOut from EX/MEM.
  - misaligned = (memRead|memWrite) & (address[1:0] != 0).
  - If stall: hold.
- Latency: inputs to write-back outputs = 2 edges; inputs to pcSrc = 1 edge.
- Throughput: one instruction per cycle.
- A bubble (flushed or reset EX/MEM) propagates as regWriteOut=0 and performs no memory write.
- Reset mid-operation: a store captured in EX/MEM but not yet committed is discarded; any word already written stays intact.

Decomposition:
- Shared package: DATA_W, register-index width 5, MEM_AW default, and the bubble control constant (all zeros).
- One natural sub-module, data_memory: synchronous single-port RAM with ports clk, we, re, addr[MEM_AW-1:0], wdata, rdata.
- Pipeline registers stay inline in fourth_step.

Test Plan:
- Store then load:
  - Stimulus: sw with aluResult=0x0000_0010, reg2Out=0xDEAD_BEEF; next cycle lw with aluResult=0x10, memToReg=1, regWrite=1, muxRegDstOut=5.
  - Response: two edges after the lw is applied, memReadData=0xDEAD_BEEF, regDstOut=5, memToRegOut=1.
- Branch:
  - branch=1, zero=1, addResult=0x0000_0040 -> one edge later pcSrc=1, branchTarget=0x40.
  - branch=1, zero=0 -> pcSrc=0.
- Stall:
  - Stimulus: hold stall=1 for 3 cycles while presenting a sw to 0x20 with data 0x1234.
  - Response: outputs frozen and memory at 0x20 unchanged.
  - After stall drops, a lw from 0x20 returns 0x1234 only after the store completes.
- Flush:
  - Stimulus: flush=1 together with a sw to 0x08 with data 0xFFFF_FFFF and regWrite=1.
  - Response: the word at 0x08 keeps its prior value, regWriteOut=0 two edges later, pcSrc=0.
- Reset:
  - reset=1 while a sw is in EX/MEM -> next edge: all outputs 0 and the store is not committed.
  - Previously written word at 0x10 still reads 0xDEAD_BEEF afterwards.
- Misaligned and wrap:
  - lw at aluResult=0x0000_0013 -> misaligned=1, data is the word at 0x10.
  - lw at 0x0000_0090 (MEM_AW=5) -> reads the word at index 4, misaligned=0.
